// File: rtl/im2col_addr_gen.sv
// im2col address generator.
// Walks a T x T x C tensor with a K x K window at stride S over N x N output
// positions and emits one tensor element address per beat. Each im2col row
// (one output position) holds L = K*K*C data beats and is then padded with
// pad beats up to a multiple of S2P lanes.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, para_en       run request (honoured only in IDLE with para_en high)
//   tensor_size (T), kernel_size (K), stride (S), channels (C), ofs (N-1)
//   addr, addr_valid     beat address / valid (addr is 0 on pad beats)
//   addr_ready           downstream accept
//   pad, row_last, last  beat is padding / final beat of row / final beat of run
//   busy, done           high in LOAD and RUN / one-cycle end-of-run pulse

`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module im2col_addr_gen #(
    parameter int unsigned S2P = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       para_en,
    input  logic [`TENSOR_SIZE-1:0]    tensor_size,
    input  logic [`KERNEL_SIZE-1:0]    kernel_size,
    input  logic [`STRIDE_SIZE-1:0]    stride,
    input  logic [`CHANNELS_SIZE-1:0]  channels,
    input  logic [`TENSOR_SIZE-1:0]    ofs,
    output logic [`ADDR_SIZE-1:0]      addr,
    output logic                       addr_valid,
    input  logic                       addr_ready,
    output logic                       pad,
    output logic                       row_last,
    output logic                       last,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned TW = `TENSOR_SIZE;
    localparam int unsigned KW = `KERNEL_SIZE;
    localparam int unsigned SW = `STRIDE_SIZE;
    localparam int unsigned CW = `CHANNELS_SIZE;
    localparam int unsigned AW = `ADDR_SIZE;
    // Row length including padding; one spare bit for the round-up.
    localparam int unsigned LW = 2 * KW + CW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e          state_q;
    logic [TW-1:0]   t_q, n1_q, ox_q, oy_q;
    logic [KW-1:0]   k_q, kc_q, kr_q;
    logic [SW-1:0]   s_q;
    logic [CW-1:0]   c_q, ch_q;
    logic [AW-1:0]   tt_q, ts_q;
    logic [LW-1:0]   len_q, tot_q, beat_q;
    // pos: oy*S*T + ox*S; oyb: oy*S*T; chp: pos + c*T*T; rowp: chp + kr*T
    logic [AW-1:0]   pos_q, oyb_q, chp_q, rowp_q;

    logic [LW-1:0]   len_w, rem_w, tot_w;
    logic [TW-1:0]   ox_d, oy_d;
    logic [KW-1:0]   kc_d, kr_d;
    logic [CW-1:0]   ch_d;
    logic [LW-1:0]   beat_d;
    logic [AW-1:0]   pos_d, oyb_d, chp_d, rowp_d, addr_d;
    logic            pad_d, row_last_d, last_d;

    // Row geometry from the captured parameters; only used in LOAD.
    always_comb begin
        len_w = LW'(k_q) * LW'(k_q) * LW'(c_q);
        rem_w = len_w % LW'(S2P);
        tot_w = (rem_w == '0) ? len_w : len_w + LW'(S2P) - rem_w;
    end

    // Next beat after a transfer in RUN, built only from adds of base registers.
    always_comb begin
        beat_d = beat_q + LW'(1);
        kc_d   = kc_q;
        kr_d   = kr_q;
        ch_d   = ch_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        pos_d  = pos_q;
        oyb_d  = oyb_q;
        chp_d  = chp_q;
        rowp_d = rowp_q;
        addr_d = addr;
        pad_d  = 1'b0;
        if (beat_q == tot_q - LW'(1)) begin
            // Row done: step to the next output position.
            beat_d = '0;
            kc_d   = '0;
            kr_d   = '0;
            ch_d   = '0;
            if (ox_q == n1_q) begin
                ox_d  = '0;
                oy_d  = oy_q + TW'(1);
                oyb_d = oyb_q + ts_q;
                pos_d = oyb_q + ts_q;
            end else begin
                ox_d  = ox_q + TW'(1);
                pos_d = pos_q + AW'(s_q);
            end
            chp_d  = pos_d;
            rowp_d = pos_d;
            addr_d = pos_d;
        end else if (beat_d >= len_q) begin
            pad_d  = 1'b1;
            addr_d = '0;
        end else if (kc_q != k_q - KW'(1)) begin
            kc_d   = kc_q + KW'(1);
            addr_d = addr + AW'(1);
        end else if (kr_q != k_q - KW'(1)) begin
            kc_d   = '0;
            kr_d   = kr_q + KW'(1);
            rowp_d = rowp_q + AW'(t_q);
            addr_d = rowp_d;
        end else begin
            kc_d   = '0;
            kr_d   = '0;
            ch_d   = ch_q + CW'(1);
            chp_d  = chp_q + tt_q;
            rowp_d = chp_d;
            addr_d = chp_d;
        end
        row_last_d = (beat_d == tot_q - LW'(1));
        last_d     = row_last_d && (ox_d == n1_q) && (oy_d == n1_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            t_q        <= '0;
            k_q        <= '0;
            s_q        <= '0;
            c_q        <= '0;
            n1_q       <= '0;
            tt_q       <= '0;
            ts_q       <= '0;
            len_q      <= '0;
            tot_q      <= '0;
            beat_q     <= '0;
            kc_q       <= '0;
            kr_q       <= '0;
            ch_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            pos_q      <= '0;
            oyb_q      <= '0;
            chp_q      <= '0;
            rowp_q     <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            pad        <= 1'b0;
            row_last   <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && para_en) begin
                        t_q     <= tensor_size;
                        k_q     <= kernel_size;
                        s_q     <= stride;
                        c_q     <= channels;
                        n1_q    <= ofs;
                        busy    <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    tt_q   <= AW'(t_q) * AW'(t_q);
                    ts_q   <= AW'(t_q) * AW'(s_q);
                    len_q  <= len_w;
                    tot_q  <= tot_w;
                    beat_q <= '0;
                    kc_q   <= '0;
                    kr_q   <= '0;
                    ch_q   <= '0;
                    ox_q   <= '0;
                    oy_q   <= '0;
                    pos_q  <= '0;
                    oyb_q  <= '0;
                    chp_q  <= '0;
                    rowp_q <= '0;
                    if (k_q == '0 || c_q == '0) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        addr       <= '0;
                        pad        <= 1'b0;
                        row_last   <= (tot_w == LW'(1));
                        last       <= (tot_w == LW'(1)) && (n1_q == '0);
                        addr_valid <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (addr_ready) begin
                        if (last) begin
                            addr       <= '0;
                            addr_valid <= 1'b0;
                            pad        <= 1'b0;
                            row_last   <= 1'b0;
                            last       <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            beat_q   <= beat_d;
                            kc_q     <= kc_d;
                            kr_q     <= kr_d;
                            ch_q     <= ch_d;
                            ox_q     <= ox_d;
                            oy_q     <= oy_d;
                            pos_q    <= pos_d;
                            oyb_q    <= oyb_d;
                            chp_q    <= chp_d;
                            rowp_q   <= rowp_d;
                            addr     <= addr_d;
                            pad      <= pad_d;
                            row_last <= row_last_d;
                            last     <= last_d;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im2col_addr_gen.sv
// Directed bench for im2col_addr_gen: reference sequences, ready stalls,
// mid-run reset, ignored starts and the empty-kernel case.

`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module tb_im2col_addr_gen;

    localparam int S2P = 8;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      start;
    logic                      para_en;
    logic [`TENSOR_SIZE-1:0]   tensor_size;
    logic [`KERNEL_SIZE-1:0]   kernel_size;
    logic [`STRIDE_SIZE-1:0]   stride;
    logic [`CHANNELS_SIZE-1:0] channels;
    logic [`TENSOR_SIZE-1:0]   ofs;
    logic [`ADDR_SIZE-1:0]     addr;
    logic                      addr_valid;
    logic                      addr_ready;
    logic                      pad;
    logic                      row_last;
    logic                      last;
    logic                      busy;
    logic                      done;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned g_beat[$];
    int unsigned e_beat[$];

    im2col_addr_gen #(.S2P(S2P)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .para_en    (para_en),
        .tensor_size(tensor_size),
        .kernel_size(kernel_size),
        .stride     (stride),
        .channels   (channels),
        .ofs        (ofs),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .pad        (pad),
        .row_last   (row_last),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beats are packed as {last, row_last, pad, addr[15:0]}.
    function automatic int unsigned pack(input int unsigned a, input bit p, input bit rl,
                                         input bit l);
        return {13'd0, l, rl, p, a[15:0]};
    endfunction

    task automatic build_exp(input int t, input int k, input int s, input int c, input int n1);
        int l, p;
        bit fl;
        e_beat.delete();
        l = k * k * c;
        p = (S2P - l % S2P) % S2P;
        for (int oy = 0; oy <= n1; oy++) begin
            for (int ox = 0; ox <= n1; ox++) begin
                fl = (oy == n1) && (ox == n1);
                for (int cc = 0; cc < c; cc++)
                    for (int kr = 0; kr < k; kr++)
                        for (int kc = 0; kc < k; kc++) begin
                            bit rl;
                            rl = (p == 0) && (cc == c - 1) && (kr == k - 1) && (kc == k - 1);
                            e_beat.push_back(pack(cc * t * t + (oy * s + kr) * t + ox * s + kc,
                                                  1'b0, rl, rl && fl));
                        end
                for (int j = 0; j < p; j++)
                    e_beat.push_back(pack(0, 1'b1, j == p - 1, (j == p - 1) && fl));
            end
        end
    endtask

    task automatic compare_run(input string tag);
        int n;
        check({tag, "_count"}, g_beat.size(), e_beat.size());
        n = (g_beat.size() < e_beat.size()) ? g_beat.size() : e_beat.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), g_beat[i], e_beat[i]);
    endtask

    // Launch a run, then scramble the inputs to show they were captured.
    task automatic kick(input int t, input int k, input int s, input int c, input int n1);
        @(negedge clk);
        tensor_size = t[7:0];
        kernel_size = k[3:0];
        stride      = s[3:0];
        channels    = c[7:0];
        ofs         = n1[7:0];
        start       = 1'b1;
        para_en     = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        para_en     = 1'b0;
        tensor_size = 8'd9;
        kernel_size = 4'd5;
        stride      = 4'd3;
        channels    = 8'd3;
        ofs         = 8'd4;
        check("load_busy", busy, 1'b1);
        check("load_valid", addr_valid, 1'b0);
    endtask

    // Record beats until last (or stop_at beats); optional ready stall and start pulse.
    task automatic collect(input int stall_at, input int stall_len, input int pulse_at,
                           input int stop_at);
        int cyc;
        bit fin;
        logic [15:0] a0;
        logic [2:0]  f0;
        fin = 1'b0;
        cyc = 0;
        g_beat.delete();
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            para_en = 1'b0;
            if (addr_valid && addr_ready) begin
                g_beat.push_back(pack(addr, pad, row_last, last));
                if (last || g_beat.size() == stop_at) fin = 1'b1;
                if (g_beat.size() == pulse_at) begin
                    start   = 1'b1;
                    para_en = 1'b1;
                end
                if (g_beat.size() == stall_at) begin
                    a0 = addr;
                    f0 = {pad, row_last, last};
                    addr_ready = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        cyc++;
                        start   = 1'b0;
                        para_en = 1'b0;
                        check("stall_addr", addr, a0);
                        check("stall_flags", {addr_valid, pad, row_last, last}, {1'b1, f0});
                    end
                    addr_ready = 1'b1;
                end
            end
        end
        if (!fin) check("collect_timeout", 1'b0, 1'b1);
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, {done, busy, addr_valid}, 3'b100);
        @(negedge clk);
        check({tag, "_done_off"}, {done, busy, addr_valid}, 3'b000);
    endtask

    initial begin
        int row0_a[9];
        int row0_c[8];
        int starts_b[4];
        row0_a   = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        row0_c   = '{0, 1, 4, 5, 16, 17, 20, 21};
        starts_b = '{0, 2, 10, 12};

        rstn = 1'b0; start = 1'b0; para_en = 1'b0; addr_ready = 1'b1;
        tensor_size = '0; kernel_size = '0; stride = '0; channels = '0; ofs = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {addr, addr_valid, pad, row_last, last, busy, done}, '0);
        rstn = 1'b1;

        // start without para_en is ignored
        @(negedge clk);
        tensor_size = 8'd4; kernel_size = 4'd3; stride = 4'd1; channels = 8'd1; ofs = 8'd1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("noparaen_idle", {busy, addr_valid, done}, 3'b000);
        start = 1'b0;

        // T=4 K=3 S=1 C=1 N=2
        kick(4, 3, 1, 1, 1);
        collect(0, 0, 0, 0);
        post_done("a");
        build_exp(4, 3, 1, 1, 1);
        compare_run("a");
        if (g_beat.size() == 64) begin
            for (int i = 0; i < 9; i++) check($sformatf("a_row0_%0d", i), g_beat[i][15:0], row0_a[i]);
            for (int i = 9; i < 16; i++) check($sformatf("a_pad%0d", i), g_beat[i][16], 1'b1);
            check("a_rowlast15", g_beat[15][17], 1'b1);
            check("a_last63", g_beat[63][18], 1'b1);
        end

        // T=5 K=3 S=2 C=1 N=2: row starts
        kick(5, 3, 2, 1, 1);
        collect(0, 0, 0, 0);
        post_done("b");
        build_exp(5, 3, 2, 1, 1);
        compare_run("b");
        if (g_beat.size() == 64)
            for (int i = 0; i < 4; i++)
                check($sformatf("b_start%0d", i), g_beat[i * 16][15:0], starts_b[i]);

        // T=4 K=2 S=2 C=2 N=2, ready stall mid-row and a start pulse mid-run
        kick(4, 2, 2, 2, 1);
        collect(5, 3, 10, 0);
        post_done("c");
        build_exp(4, 2, 2, 2, 1);
        compare_run("c");
        if (g_beat.size() == 32) begin
            for (int i = 0; i < 8; i++) check($sformatf("c_row0_%0d", i), g_beat[i][15:0], row0_c[i]);
            check("c_beat7_flags", g_beat[7][17:16], 2'b10);
        end
        repeat (2) @(negedge clk);
        check("c_no_restart", {busy, addr_valid}, 2'b00);

        // reset at beat 20, then restart from scratch
        kick(4, 3, 1, 1, 1);
        collect(0, 0, 0, 20);
        rstn = 1'b0;
        #1;
        check("d_rst_outputs", {addr, addr_valid, pad, row_last, last, busy, done}, '0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("d_no_resume", {busy, addr_valid, done}, 3'b000);
        kick(4, 3, 1, 1, 1);
        collect(0, 0, 0, 0);
        post_done("d");
        build_exp(4, 3, 1, 1, 1);
        compare_run("d");

        // K=0: no beats, done two cycles after start
        @(negedge clk);
        tensor_size = 8'd4; kernel_size = 4'd0; stride = 4'd1; channels = 8'd1; ofs = 8'd1;
        start = 1'b1; para_en = 1'b1;
        @(negedge clk);
        start = 1'b0; para_en = 1'b0;
        check("k0_load", {busy, done, addr_valid}, 3'b100);
        @(negedge clk);
        check("k0_done", {busy, done, addr_valid}, 3'b010);
        @(negedge clk);
        check("k0_idle", {busy, done, addr_valid}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im2col_addr_gen.md
IM2COL_ADDR_GEN -- requirements
Module: im2col_addr_gen

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-004 SHALL have port para_en  input  1  parameter-valid from the parameter-prepare block; start ignored while low.
REQ-005 SHALL have port tensor_size  input  `TENSOR_SIZE  input tensor edge T.
REQ-006 SHALL have port kernel_size  input  `KERNEL_SIZE  kernel edge K.
REQ-007 SHALL have port stride  input  `STRIDE_SIZE  stride S.
REQ-008 SHALL have port channels  input  `CHANNELS_SIZE  channel count C.
REQ-009 SHALL have port ofs  input  `TENSOR_SIZE  output positions per dimension minus 1 (N-1).
REQ-010 SHALL have port addr  output  `ADDR_SIZE  tensor element address.
REQ-011 SHALL have port addr_valid  output  1  addr/pad/row_last/last valid.
REQ-012 SHALL have port addr_ready  input  1  downstream accept.
REQ-013 SHALL have port pad  output  1  beat is lane padding; addr is 0.
REQ-014 SHALL have port row_last  output  1  final beat of one im2col row.
REQ-015 SHALL have port last  output  1  final beat of the whole run.
REQ-016 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-019 IDLE->LOAD SHALL occur when start&&para_en; T, K, S, C, N-1 SHALL be captured that cycle; later input changes SHALL have no effect until next IDLE.
REQ-020 LOAD SHALL last exactly one cycle and compute T*T, T*S, and row length L=K*K*C.
REQ-021 If K==0 or C==0 at capture, LOAD SHALL go to DONE with no beats emitted.
REQ-022 One im2col row per output position, order oy outer, ox inner (0..N-1 each); within a row, c outer, kr middle, kc inner.
REQ-023 Data beat address SHALL be c*T*T + (oy*S+kr)*T + ox*S + kc, modulo 2^`ADDR_SIZE.
REQ-024 Addresses SHALL be formed by incrementing base registers (T, T*S, T*T, S steps); no multiplier in the RUN path.
REQ-025 After the L data beats of a row, P = (S2P-L%S2P)%S2P pad beats SHALL follow (pad=1, addr=0); row_last SHALL be on the row's final beat (data or pad).
REQ-026 A beat SHALL transfer on addr_valid&&addr_ready; addr_valid SHALL be high throughout RUN and first high the cycle after LOAD.
REQ-027 With addr_ready low, addr/pad/row_last/last SHALL hold stable.
REQ-028 Throughput SHALL be one beat per cycle with addr_ready held high.
REQ-029 last SHALL be set with row_last on the final row (oy=ox=N-1); that transfer SHALL move RUN->DONE.
REQ-030 DONE SHALL assert done for one cycle, then return to IDLE; start in any non-IDLE state SHALL be ignored.
REQ-031 busy SHALL be 1 exactly in LOAD and RUN.

Reset
REQ-032 rstn low SHALL immediately force IDLE and clear addr, addr_valid, pad, row_last, last, busy, done, and all counters to 0, including mid-run; no run resumes after release.
REQ-033 After rstn rises, the first run SHALL start only on a new start&&para_en in IDLE.

Verification
REQ-034 T=4,K=3,S=1,C=1,N-1=1,S2P=8, ready=1 -> row0 addrs 0,1,2,4,5,6,8,9,10 then 7 pad beats; 64 beats total; last on beat 64; done one cycle later.
REQ-035 T=5,K=3,S=2,C=1,N-1=1 -> row starts 0, 2, 10, 12.
REQ-036 T=4,K=2,S=2,C=2,N-1=1,S2P=8 -> row0 0,1,4,5,16,17,20,21, no pad, row_last on 8th beat.
REQ-037 Drop addr_ready for 3 cycles mid-row -> addr and flags unchanged; sequence continues with no skipped or duplicated beat.
REQ-038 Assert rstn low at beat 20 of REQ-034 -> all outputs 0 that cycle; re-start yields the sequence from address 0.
REQ-039 start with para_en=0, and start during RUN -> no effect; K=0 -> done pulse two cycles after start with no beats emitted.
